// File: rtl/blur_row_writer_if.sv
// Row-input and SRAM-write signal bundle for blur_row_writer.
// The slave view belongs to the writer; the master view belongs to whatever drives it.
interface blur_row_writer_if #(
    parameter int DATA_W = 5120
);
    logic [2:0]        buffer_mode;
    logic              start;
    logic [1:0]        layer_sel;
    logic              row_valid;
    logic [DATA_W-1:0] row_data;
    logic              row_ready;
    logic              sram_we;
    logic [1:0]        sram_sel;
    logic [8:0]        sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_grant;
    logic              busy;
    logic              done;

    modport slave (
        input  buffer_mode, start, layer_sel, row_valid, row_data, sram_grant,
        output row_ready, sram_we, sram_sel, sram_addr, sram_wdata, busy, done
    );

    modport master (
        output buffer_mode, start, layer_sel, row_valid, row_data, sram_grant,
        input  row_ready, sram_we, sram_sel, sram_addr, sram_wdata, busy, done
    );
endinterface

// File: rtl/blur_row_writer.sv
// Streams one blurred image layer, row by row, through a small FIFO into the selected blur SRAM bank.
// Define WRITER_ZERO_BORDER_EN to force the two top and two bottom rows of each layer to zero.
module blur_row_writer #(
    parameter int ROW_NUM    = 480,
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = 5120
) (
    input  logic             clk,
    input  logic             rst,
    blur_row_writer_if.slave bus
);
    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [8:0]       LAST_ROW   = 9'(ROW_NUM - 1);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [2:0]       MODE_IDLE  = 3'd0;
    localparam logic [2:0]       MODE_GAUSS = 3'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [8:0]        in_cnt_q, in_cnt_d;
    logic [8:0]        out_cnt_q, out_cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic              fifo_full;
    logic              fifo_empty;
    logic              active;
    logic              abort;
    logic              ready;
    logic              we;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] push_data;

`ifdef WRITER_ZERO_BORDER_EN
    function automatic logic is_border_row(input logic [8:0] cnt);
        return (cnt == 9'd0) || (cnt == 9'd1) ||
               (cnt == LAST_ROW - 9'd1) || (cnt == LAST_ROW);
    endfunction

    assign push_data = is_border_row(in_cnt_q) ? '0 : bus.row_data;
`else
    assign push_data = bus.row_data;
`endif

    assign fifo_full  = (count_q == FIFO_FULL);
    assign fifo_empty = (count_q == '0);
    assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign abort      = (bus.buffer_mode == MODE_IDLE);

    assign ready = (state_q == S_RUN) && !fifo_full && (in_cnt_q <= LAST_ROW);
    assign we    = active && !fifo_empty;
    assign push  = bus.row_valid && ready;
    assign pop   = we && bus.sram_grant;

    // The FIFO head is held on the bus until granted; the bus reads zero while no write is pending.
    assign bus.row_ready  = ready;
    assign bus.sram_we    = we;
    assign bus.sram_addr  = out_cnt_q;
    assign bus.sram_wdata = we ? mem_q[rd_ptr_q] : '0;
    assign bus.sram_sel   = sel_q;
    assign bus.busy       = active;
    assign bus.done       = (state_q == S_DONE);

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        if (abort) begin
            state_d   = S_IDLE;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
        end else begin
            // Counters saturate at the last row so the address never wraps inside a pass.
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (in_cnt_q != LAST_ROW) begin
                    in_cnt_d = in_cnt_q + 9'd1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
                if (out_cnt_q != LAST_ROW) begin
                    out_cnt_d = out_cnt_q + 9'd1;
                end
            end

            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase

            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && (bus.buffer_mode == MODE_GAUSS)) begin
                        state_d   = S_RUN;
                        sel_d     = bus.layer_sel;
                        in_cnt_d  = '0;
                        out_cnt_d = '0;
                    end
                end
                S_RUN: begin
                    if (push && (in_cnt_q == LAST_ROW)) begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (pop && (out_cnt_q == LAST_ROW)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Row storage carries no reset; occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push && !abort) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end
endmodule
